flag_state_sequencer: RTL and testbench

- Registered controller that sequences a 2-bit state code through IDLE -> LOAD -> RUN -> DONE and drives the matching 2-bit flag.
- Sits ahead of the state-to-flag decode datapath. Supplies curr_state every cycle and a fully specified flag for every code, so no latch is ever inferred downstream.
- Start/busy handshake on the requester side; done/done_ack handshake on the consumer side.

---
 rtl/flag_state_sequencer_pkg.sv | 25 ++
 rtl/flag_state_sequencer_if.sv | 31 +++
 rtl/flag_state_sequencer_flag_decode.sv | 28 ++
 rtl/flag_state_sequencer.sv | 127 ++++++++++++
 tb/tb_flag_state_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/flag_state_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flag_state_sequencer_pkg
// Description : Shared state codes and flag constants for the flag state
//               sequencer and its flag decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package flag_state_sequencer_pkg;

  // 2-bit state code presented on curr_state
  typedef logic [1:0] state_t;
  // 2-bit decoded flag
  typedef logic [1:0] flag_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam flag_t FLAG_A = 2'd2;
  localparam flag_t FLAG_B = 2'd1;
  localparam flag_t FLAG_Z = 2'd0;

endpackage
`default_nettype wire

// File: rtl/flag_state_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : flag_state_sequencer_if
// Description : Requester/consumer handshake bundle of the flag state
//               sequencer. master = requester/consumer side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface flag_state_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] run_len;
  logic             abort;
  logic             done_ack;
  logic             busy;
  logic [1:0]       curr_state;
  logic [1:0]       flag;
  logic             done;
  logic [CNT_W-1:0] runs_done;

  modport master (
    output start, run_len, abort, done_ack,
    input  busy, curr_state, flag, done, runs_done
  );

  modport slave (
    input  start, run_len, abort, done_ack,
    output busy, curr_state, flag, done, runs_done
  );
endinterface
`default_nettype wire

// File: rtl/flag_state_sequencer_flag_decode.sv
`default_nettype none
// ============================================================================
// Module      : flag_decode
// Description : Complete state-code to flag decode. Every code maps to a
//               defined flag so no storage is ever implied.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_decode
  import flag_state_sequencer_pkg::*;
(
  input  wire  state_t state_i,
  output flag_t        flag_o
);

  // Default first, then a full case over all four codes
  always_comb begin
    flag_o = FLAG_A;
    case (state_i)
      ST_IDLE: flag_o = FLAG_A;
      ST_LOAD: flag_o = FLAG_A;
      ST_RUN:  flag_o = FLAG_B;
      ST_DONE: flag_o = FLAG_Z;
      default: flag_o = FLAG_A;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/flag_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flag_state_sequencer
// Description : Sequences IDLE -> LOAD -> RUN -> DONE with a dwell counter,
//               start/busy and done/done_ack handshakes, abort, and a
//               wrapping count of completed sequences. All outputs are
//               registered from the next-state values so they stay aligned
//               with curr_state.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_state_sequencer
  import flag_state_sequencer_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int LOAD_CYCLES = 2
) (
  input  wire                    clk,
  input  wire                    rst_n,
  flag_state_sequencer_if.slave  bus_if
);

  // LOAD dwell reload value, truncated to the counter width
  localparam logic [CNT_W-1:0] C_LOAD_INIT = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic [CNT_W-1:0] runs_q,  runs_d;
  flag_t            flag_q,  flag_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // State register plus registered outputs, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      runs_q  <= '0;
      flag_q  <= FLAG_A;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      runs_q  <= runs_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter logic; abort beats counter expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    runs_d  = runs_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.start) begin
          len_d   = bus_if.run_len;
          cnt_d   = C_LOAD_INIT;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus_if.abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          if (len_q == '0) begin
            // Zero-length run skips RUN entirely
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            state_d = ST_RUN;
            cnt_d   = len_q - C_ONE;
          end
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      ST_RUN: begin
        if (bus_if.abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      ST_DONE: begin
        if (bus_if.done_ack) begin
          state_d = ST_IDLE;
          runs_d  = runs_q + C_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode computed from the next state so registers align with it
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  flag_decode u_flag_decode (
    .state_i (state_d),
    .flag_o  (flag_d)
  );

  assign bus_if.curr_state = state_q;
  assign bus_if.flag       = flag_q;
  assign bus_if.busy       = busy_q;
  assign bus_if.done       = done_q;
  assign bus_if.runs_done  = runs_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_state_sequencer
// Description : Scoreboard bench for flag_state_sequencer. A phase/elapsed
//               reference model pushes the expected outputs at every rising
//               edge; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_state_sequencer;

  localparam int CNT_W       = 8;
  localparam int LOAD_CYCLES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  flag_state_sequencer_if #(.CNT_W(CNT_W)) bus ();

  flag_state_sequencer #(
    .CNT_W       (CNT_W),
    .LOAD_CYCLES (LOAD_CYCLES)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       st;
    logic [1:0]       fl;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] runs;
  } obs_t;

  obs_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: phase number, cycles elapsed in phase, captured length
  int m_st   = 0;
  int m_el   = 0;
  int m_len  = 0;
  int m_runs = 0;

  function automatic obs_t expect_of(int st, int runs);
    obs_t e;
    e.st   = 2'(st);
    e.fl   = (st < 2) ? 2'd2 : 2'(3 - st);
    e.busy = (st != 0);
    e.done = (st == 3);
    e.runs = CNT_W'(runs);
    return e;
  endfunction

  // Model advances on each rising edge and enqueues what the DUT must show
  always @(posedge clk) begin
    if (!rst_n) begin
      m_st = 0; m_el = 0; m_len = 0; m_runs = 0;
    end else begin
      case (m_st)
        0: if (bus.start) begin
             m_len = int'(bus.run_len); m_st = 1; m_el = 0;
           end
        1: if (bus.abort) begin
             m_st = 0;
           end else if (m_el + 1 >= LOAD_CYCLES) begin
             m_st = (m_len == 0) ? 3 : 2; m_el = 0;
           end else begin
             m_el = m_el + 1;
           end
        2: if (bus.abort) begin
             m_st = 0;
           end else if (m_el + 1 >= m_len) begin
             m_st = 3; m_el = 0;
           end else begin
             m_el = m_el + 1;
           end
        default: if (bus.done_ack) begin
             m_st = 0; m_runs = (m_runs + 1) % (1 << CNT_W);
           end
      endcase
    end
    sb_q.push_back(expect_of(m_st, m_runs));
  end

  obs_t mon_e, mon_a;

  // Monitor: compare DUT outputs against the queued expectation
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_a = {bus.curr_state, bus.flag, bus.busy, bus.done, bus.runs_done};
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL cycle_check t=%0t got st=%0d flag=%0d busy=%0d done=%0d runs=%0d exp st=%0d flag=%0d busy=%0d done=%0d runs=%0d",
                 $time, mon_a.st, mon_a.fl, mon_a.busy, mon_a.done, mon_a.runs,
                 mon_e.st, mon_e.fl, mon_e.busy, mon_e.done, mon_e.runs);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One sequence: start, LOAD+RUN cycles with optional abort/start noise,
  // then hold DONE for ack_wait cycles before acknowledging
  task automatic run_seq(input int len, input int abort_at, input int ack_wait,
                         input bit start_noise, input bit start_with_ack);
    int lim;
    lim = LOAD_CYCLES + len;
    bus.start   = 1'b1;
    bus.run_len = CNT_W'(len);
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < lim; i++) begin
      bus.abort = (i == abort_at);
      bus.start = start_noise && (i >= LOAD_CYCLES);
      cyc();
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    if (abort_at < lim) begin
      cyc();
      return;
    end
    repeat (ack_wait) cyc();
    bus.done_ack = 1'b1;
    bus.start    = start_with_ack;
    cyc();
    bus.done_ack = 1'b0;
    bus.start    = 1'b0;
    cyc();
  endtask

  task automatic check_direct(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.run_len  = '0;
    bus.abort    = 1'b0;
    bus.done_ack = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    run_seq(3, 99, 4, 1'b0, 1'b0);   // basic sequence, DONE held 4 cycles
    run_seq(0, 99, 1, 1'b0, 1'b0);   // zero-length run skips RUN
    run_seq(5, 3, 0, 1'b0, 1'b0);    // abort in second RUN cycle
    run_seq(4, 1, 0, 1'b0, 1'b0);    // abort coincides with LOAD expiry
    run_seq(4, 99, 2, 1'b1, 1'b0);   // start pulses during RUN ignored
    run_seq(2, 99, 0, 1'b0, 1'b1);   // start together with ack ignored
    run_seq(1, 99, 0, 1'b0, 1'b0);
    repeat (3) cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.start    = ($urandom_range(0, 99) < 30);
      bus.run_len  = CNT_W'($urandom_range(0, 6));
      bus.abort    = ($urandom_range(0, 99) < 6);
      bus.done_ack = ($urandom_range(0, 99) < 30);
      cyc();
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.done_ack = 1'b0;
    repeat (12) cyc();

    // Asynchronous reset in the middle of RUN, checked before the next edge
    bus.start   = 1'b1;
    bus.run_len = CNT_W'(6);
    cyc();
    bus.start = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_direct("async_rst_state", 32'(bus.curr_state), 32'd0);
    check_direct("async_rst_flag",  32'(bus.flag),       32'd2);
    check_direct("async_rst_busy",  32'(bus.busy),       32'd0);
    check_direct("async_rst_done",  32'(bus.done),       32'd0);
    check_direct("async_rst_runs",  32'(bus.runs_done),  32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    // 256 completions wrap runs_done back to zero
    for (int k = 0; k < 256; k++) begin
      bus.start   = 1'b1;
      bus.run_len = '0;
      cyc();
      bus.start = 1'b0;
      repeat (LOAD_CYCLES) cyc();
      bus.done_ack = 1'b1;
      cyc();
      bus.done_ack = 1'b0;
    end
    cyc();
    @(negedge clk);
    #1;
    check_direct("runs_wrap", 32'(bus.runs_done), 32'd0);
    check_direct("scoreboard_activity", 32'(total > 1000), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
